// File: rtl/mul_unit_cdb.sv
// mul_unit_cdb: pipelined multiply unit with a FIFO result buffer that broadcasts {tag,data} on the CDB.
module mul_unit_cdb #(
  parameter int DATA_W     = 8,
  parameter int TAG_W      = 3,
  parameter int LATENCY    = 3,
  parameter int OBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic [DATA_W-1:0] issue_op_a,
  input  logic [DATA_W-1:0] issue_op_b,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [DATA_W-1:0] MUL_Output,
  output logic [TAG_W-1:0]  MUL_Tag_op,
  output logic [3:0]        in_flight
);
  localparam int PW = OBUF_DEPTH > 1 ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  logic [LATENCY-1:0] r_v;
  logic [TAG_W-1:0]   r_tag   [LATENCY];
  logic [DATA_W-1:0]  r_data  [LATENCY];
  logic [TAG_W-1:0]   r_btag  [OBUF_DEPTH];
  logic [DATA_W-1:0]  r_bdata [OBUF_DEPTH];
  logic [PW-1:0]      r_rd, r_wr;
  logic [CW-1:0]      r_cnt;
  logic [3:0]         r_in_flight;
  logic               w_full, w_pop, w_push, w_stall, w_accept;
  logic [DATA_W-1:0]  w_prod;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(OBUF_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign w_full      = r_cnt == CW'(OBUF_DEPTH);
  assign cdb_req     = r_cnt != '0;
  assign w_pop       = cdb_req & cdb_grant;
  // A grant in the same cycle frees a slot, so a full buffer only stalls without one.
  assign w_stall     = r_v[LATENCY-1] & w_full & ~w_pop;
  assign issue_ready = ~w_stall;
  assign w_accept    = issue_valid & ~w_stall & (issue_tag != '0);
  assign w_push      = r_v[LATENCY-1] & ~w_stall;
  assign w_prod      = issue_op_a * issue_op_b;
  assign MUL_Output  = cdb_req ? r_bdata[r_rd] : '0;
  assign MUL_Tag_op  = cdb_req ? r_btag[r_rd] : '0;
  assign in_flight   = r_in_flight;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_v <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (!w_stall) begin
      r_v[0]    <= w_accept;
      r_tag[0]  <= issue_tag;
      r_data[0] <= w_prod;
      for (int i = 1; i < LATENCY; i++) begin
        r_v[i]    <= r_v[i-1];
        r_tag[i]  <= r_tag[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd        <= '0;
      r_wr        <= '0;
      r_cnt       <= '0;
      r_in_flight <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        r_btag[i]  <= '0;
        r_bdata[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_btag[r_wr]  <= r_tag[LATENCY-1];
        r_bdata[r_wr] <= r_data[LATENCY-1];
        r_wr          <= nxt(r_wr);
      end
      if (w_pop) r_rd <= nxt(r_rd);
      r_cnt       <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_in_flight <= r_in_flight + 4'(w_accept) - 4'(w_pop);
    end
endmodule
